// File: rtl/double_floor_pkg.sv
// Shared definitions for the double_floor arbiter: default pipeline latency,
// default result-buffer depth, and the {valid,id} tag that tracks each operand
// through the shared floor unit.
package double_floor_pkg;

    localparam int LATENCY_DEF = 3;
    localparam int DEPTH_DEF   = 4;

    // Tag layout: bit 1 = valid, bit 0 = requester id.
    localparam int TAG_W   = 2;
    localparam int TAG_VLD = 1;
    localparam int TAG_ID  = 0;

    typedef logic [TAG_W-1:0] tag_t;

    function automatic tag_t make_tag(input logic vld, input logic id);
        tag_t t;
        t          = '0;
        t[TAG_VLD] = vld;
        t[TAG_ID]  = id;
        return t;
    endfunction

endpackage

// File: rtl/double_floor_result_fifo.sv
// Per-requester result buffer. Simultaneous write and read keep occupancy
// constant and preserve order at any fill level, including full.
module double_floor_result_fifo
    import double_floor_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         not_empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_rd;

    // Next pointers and occupancy; a read of an empty buffer is ignored.
    always_comb begin
        do_rd    = rd_en && (cnt_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, do_rd})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state is reset; storage is not.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign not_empty = (cnt_q != '0);
    assign full      = (cnt_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/double_floor_arbiter.sv
// Shares one pipelined double_floor unit between two requesters. Credits per
// requester (in flight + buffered) bound outstanding work to the buffer depth,
// so results can always be stored when they return from the unit.
module double_floor_arbiter
    import double_floor_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in0_a,
    input  logic        in0_stb,
    output logic        in0_ack,
    input  logic [63:0] in1_a,
    input  logic        in1_stb,
    output logic        in1_ack,
    output logic [63:0] out0_z,
    output logic        out0_stb,
    input  logic        out0_ack,
    output logic [63:0] out1_z,
    output logic        out1_stb,
    input  logic        out1_ack,
    output logic [63:0] floor_a,
    input  logic [63:0] floor_z
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] credit0_q, credit0_d, credit1_q, credit1_d;
    logic          last_q, last_d;
    logic [63:0]   floor_a_q, floor_a_d;
    tag_t          tag_q [LATENCY+1];
    tag_t          tag_d [LATENCY+1];
    tag_t          tag_last;

    logic elig0, elig1, gnt0, gnt1;
    logic out_xfer0, out_xfer1, wr0, wr1;
    logic ne0, ne1, full0, full1;

    // Arbitration, credit accounting and operand/tag pipeline next state.
    always_comb begin
        elig0 = !rst && in0_stb && (credit0_q < CW'(DEPTH));
        elig1 = !rst && in1_stb && (credit1_q < CW'(DEPTH));
        // On a tie the requester that was not granted last wins.
        gnt0  = elig0 && (!elig1 || last_q);
        gnt1  = elig1 && (!elig0 || !last_q);

        out_xfer0 = out0_stb && out0_ack;
        out_xfer1 = out1_stb && out1_ack;

        case ({gnt0, out_xfer0})
            2'b10:   credit0_d = credit0_q + CW'(1);
            2'b01:   credit0_d = credit0_q - CW'(1);
            default: credit0_d = credit0_q;
        endcase
        case ({gnt1, out_xfer1})
            2'b10:   credit1_d = credit1_q + CW'(1);
            2'b01:   credit1_d = credit1_q - CW'(1);
            default: credit1_d = credit1_q;
        endcase

        last_d    = gnt0 ? 1'b0 : (gnt1 ? 1'b1 : last_q);
        floor_a_d = gnt0 ? in0_a : (gnt1 ? in1_a : floor_a_q);

        tag_d[0] = make_tag(gnt0 || gnt1, gnt1);
        for (int k = 1; k <= LATENCY; k++) tag_d[k] = tag_q[k-1];

        tag_last = tag_q[LATENCY];
        wr0      = tag_last[TAG_VLD] && !tag_last[TAG_ID];
        wr1      = tag_last[TAG_VLD] &&  tag_last[TAG_ID];
    end

    // Control registers; reset drops every in-flight tag so stale unit results are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit0_q <= '0;
            credit1_q <= '0;
            last_q    <= 1'b1;
            floor_a_q <= '0;
            for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
        end else begin
            credit0_q <= credit0_d;
            credit1_q <= credit1_d;
            last_q    <= last_d;
            floor_a_q <= floor_a_d;
            for (int k = 0; k <= LATENCY; k++) tag_q[k] <= tag_d[k];
        end
    end

    double_floor_result_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo0 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr0),
        .wr_data  (floor_z),
        .rd_en    (out_xfer0),
        .rd_data  (out0_z),
        .not_empty(ne0),
        .full     (full0)
    );

    double_floor_result_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo1 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr1),
        .wr_data  (floor_z),
        .rd_en    (out_xfer1),
        .rd_data  (out1_z),
        .not_empty(ne1),
        .full     (full1)
    );

    assign in0_ack  = gnt0;
    assign in1_ack  = gnt1;
    assign out0_stb = ne0 && !rst;
    assign out1_stb = ne1 && !rst;
    assign floor_a  = floor_a_q;

    // The credit limit makes a write into a full buffer (without a same-cycle pop) impossible.
    a_no_overflow0: assert property (@(posedge clk) disable iff (rst) !(wr0 && full0 && !out_xfer0));
    a_no_overflow1: assert property (@(posedge clk) disable iff (rst) !(wr1 && full1 && !out_xfer1));

endmodule

// File: tb/tb_double_floor_arbiter.sv
// Bench for double_floor_arbiter with a behavioural floor unit and a per-requester scoreboard.
module tb_double_floor_arbiter;
    import double_floor_pkg::*;

    localparam int L = LATENCY_DEF;
    localparam int D = DEPTH_DEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in0_a, in1_a, out0_z, out1_z, floor_a, floor_z;
    logic        in0_stb, in1_stb, in0_ack, in1_ack;
    logic        out0_stb, out1_stb, out0_ack, out1_ack;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    double_floor_arbiter #(.LATENCY(L), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .in0_a(in0_a), .in0_stb(in0_stb), .in0_ack(in0_ack),
        .in1_a(in1_a), .in1_stb(in1_stb), .in1_ack(in1_ack),
        .out0_z(out0_z), .out0_stb(out0_stb), .out0_ack(out0_ack),
        .out1_z(out1_z), .out1_stb(out1_stb), .out1_ack(out1_ack),
        .floor_a(floor_a), .floor_z(floor_z)
    );

    // Standalone result buffer for the full-with-simultaneous-write/read case.
    logic        tf_wr, tf_rd, tf_ne, tf_full;
    logic [63:0] tf_wdata, tf_rdata;
    double_floor_result_fifo #(.DEPTH(D), .W(64)) u_fifo_t (
        .clk(clk), .rst(rst), .wr_en(tf_wr), .wr_data(tf_wdata),
        .rd_en(tf_rd), .rd_data(tf_rdata), .not_empty(tf_ne), .full(tf_full)
    );

    function automatic logic [63:0] ref_floor(input logic [63:0] a);
        return $realtobits($floor($bitstoreal(a)));
    endfunction

    // Behavioural shared floor unit: result of the operand loaded at edge t appears after edge t+L.
    logic [63:0] fu_pipe [L];
    always @(posedge clk) begin
        fu_pipe[0] <= floor_a;
        for (int k = 1; k < L; k++) fu_pipe[k] <= fu_pipe[k-1];
    end
    assign floor_z = ref_floor(fu_pipe[L-1]);

    // Scoreboard: push expected result on accept, pop and compare on output transfer.
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    logic [63:0] exp0, exp1;
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (in0_stb && in0_ack) q0.push_back(ref_floor(in0_a));
            if (in1_stb && in1_ack) q1.push_back(ref_floor(in1_a));
            if (out0_stb && out0_ack) begin
                n_total++;
                if (q0.size() == 0) $display("FAIL sb_out0: got %h, expected no result", out0_z);
                else begin
                    exp0 = q0.pop_front();
                    if (out0_z !== exp0) $display("FAIL sb_out0: got %h, expected %h", out0_z, exp0);
                    else n_pass++;
                end
            end
            if (out1_stb && out1_ack) begin
                n_total++;
                if (q1.size() == 0) $display("FAIL sb_out1: got %h, expected no result", out1_z);
                else begin
                    exp1 = q1.pop_front();
                    if (out1_z !== exp1) $display("FAIL sb_out1: got %h, expected %h", out1_z, exp1);
                    else n_pass++;
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1; in0_stb = 1'b1; in1_stb = 1'b1;
        in0_a = 64'h4004000000000000; in1_a = 64'h3FF0000000000000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (in0_ack !== 1'b0) $display("FAIL rst_in0_ack: got %b expected 0", in0_ack); else n_pass++;
        n_total++; if (in1_ack !== 1'b0) $display("FAIL rst_in1_ack: got %b expected 0", in1_ack); else n_pass++;
        n_total++; if (out0_stb !== 1'b0) $display("FAIL rst_out0_stb: got %b expected 0", out0_stb); else n_pass++;
        n_total++; if (out1_stb !== 1'b0) $display("FAIL rst_out1_stb: got %b expected 0", out1_stb); else n_pass++;
        n_total++; if (floor_a !== 64'h0) $display("FAIL rst_floor_a: got %h expected 0", floor_a); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0; in0_stb = 1'b0; in1_stb = 1'b0;
    endtask

    task automatic test_single;
        int k;
        int bad1;
        @(posedge clk); #1;
        in0_a = 64'h4004000000000000; in0_stb = 1'b1; in1_stb = 1'b0;
        out0_ack = 1'b0; out1_ack = 1'b0;
        @(negedge clk);
        n_total++; if (in0_ack !== 1'b1) $display("FAIL single_ack: got %b expected 1", in0_ack); else n_pass++;
        @(posedge clk); #1;
        in0_stb = 1'b0;
        k = 1; bad1 = 0;
        @(negedge clk);
        while (!out0_stb && k < 20) begin
            if (out1_stb) bad1++;
            @(negedge clk);
            k++;
        end
        n_total++; if (k != L + 2) $display("FAIL single_latency: got %0d expected %0d", k, L + 2); else n_pass++;
        n_total++; if (out0_z !== 64'h4000000000000000) $display("FAIL single_z: got %h expected 4000000000000000", out0_z); else n_pass++;
        n_total++; if (bad1 != 0 || out1_stb !== 1'b0) $display("FAIL single_out1_quiet: got %0d strobes expected 0", bad1); else n_pass++;
        n_total++; if (floor_a !== 64'h4004000000000000) $display("FAIL single_floor_a_hold: got %h expected 4004000000000000", floor_a); else n_pass++;
        @(posedge clk); #1; out0_ack = 1'b1;
        @(posedge clk); #1; out0_ack = 1'b0;
        @(negedge clk);
        n_total++; if (out0_stb !== 1'b0) $display("FAIL single_pop: got out0_stb %b expected 0", out0_stb); else n_pass++;
    endtask

    task automatic test_alternate;
        logic e0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        in0_a = 64'hBFF8000000000000; in1_a = 64'h3FF0000000000000;
        in0_stb = 1'b1; in1_stb = 1'b1; out0_ack = 1'b1; out1_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            e0 = ((i % 2) == 0);
            n_total++; if (in0_ack !== e0) $display("FAIL alt_gnt0 cycle %0d: got %b expected %b", i, in0_ack, e0); else n_pass++;
            n_total++; if (in1_ack !== !e0) $display("FAIL alt_gnt1 cycle %0d: got %b expected %b", i, in1_ack, !e0); else n_pass++;
            @(posedge clk); #1;
        end
        in0_stb = 1'b0; in1_stb = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (out0_stb) begin
                n_total++; if (out0_z !== 64'hC000000000000000) $display("FAIL alt_z0: got %h expected c000000000000000", out0_z); else n_pass++;
            end
            if (out1_stb) begin
                n_total++; if (out1_z !== 64'h3FF0000000000000) $display("FAIL alt_z1: got %h expected 3ff0000000000000", out1_z); else n_pass++;
            end
            @(posedge clk); #1;
        end
        n_total++; if (q0.size() + q1.size() != 0) $display("FAIL alt_drain: got %0d pending expected 0", q0.size() + q1.size()); else n_pass++;
    endtask

    task automatic test_backpressure;
        int nacc;
        in0_stb = 1'b1; in1_stb = 1'b0; out0_ack = 1'b0; out1_ack = 1'b1;
        nacc = 0;
        for (int i = 0; i < 15; i++) begin
            in0_a = $realtobits($itor(i) - 3.25);
            @(negedge clk);
            if (in0_ack) nacc++;
            @(posedge clk); #1;
        end
        n_total++; if (nacc != D) $display("FAIL bp_accepts: got %0d expected %0d", nacc, D); else n_pass++;
        @(negedge clk);
        n_total++; if (in0_ack !== 1'b0) $display("FAIL bp_stall: got %b expected 0", in0_ack); else n_pass++;
        @(posedge clk); #1;
        nacc = 0; out0_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in0_a = $realtobits($itor(i) + 20.5);
            @(negedge clk);
            if (in0_ack) nacc++;
            @(posedge clk); #1;
            out0_ack = 1'b0;
        end
        n_total++; if (nacc != 1) $display("FAIL bp_one_more: got %0d expected 1", nacc); else n_pass++;
    endtask

    task automatic test_stream;
        // Buffer 0 starts full; popping and refilling continuously exercises write+pop at every level.
        in0_stb = 1'b1; out0_ack = 1'b1;
        for (int i = 0; i < 25; i++) begin
            in0_a = $realtobits(-$itor(i) * 1.75);
            @(posedge clk); #1;
        end
        in0_stb = 1'b0;
        @(negedge clk);
        n_total++; if (in0_ack !== 1'b0) $display("FAIL stream_ack_no_stb: got %b expected 0", in0_ack); else n_pass++;
        repeat (12) @(posedge clk);
        #1;
        @(negedge clk);
        n_total++; if (q0.size() != 0) $display("FAIL stream_drain: got %0d pending expected 0", q0.size()); else n_pass++;
        n_total++; if (out0_stb !== 1'b0) $display("FAIL stream_empty: got %b expected 0", out0_stb); else n_pass++;
    endtask

    task automatic test_fifo_full_simul;
        logic [63:0] want;
        @(posedge clk); #1;
        tf_wr = 1'b1; tf_rd = 1'b0;
        for (int i = 0; i < D; i++) begin
            tf_wdata = 64'd100 + 64'(i);
            @(posedge clk); #1;
        end
        n_total++; if (tf_full !== 1'b1) $display("FAIL fifo_full: got %b expected 1", tf_full); else n_pass++;
        tf_wdata = 64'd100 + 64'(D); tf_rd = 1'b1;
        n_total++; if (tf_rdata !== 64'd100) $display("FAIL fifo_head: got %0d expected 100", tf_rdata); else n_pass++;
        @(posedge clk); #1;
        tf_wr = 1'b0; tf_rd = 1'b0;
        n_total++; if (tf_full !== 1'b1) $display("FAIL fifo_full_simul: got %b expected 1", tf_full); else n_pass++;
        for (int i = 1; i <= D; i++) begin
            want = 64'd100 + 64'(i);
            tf_rd = 1'b1;
            n_total++; if (tf_rdata !== want) $display("FAIL fifo_order: got %0d expected %0d", tf_rdata, want); else n_pass++;
            @(posedge clk); #1;
        end
        tf_rd = 1'b0;
        n_total++; if (tf_ne !== 1'b0) $display("FAIL fifo_empty: got %b expected 0", tf_ne); else n_pass++;
        tf_wr = 1'b1; tf_wdata = 64'd200;
        @(posedge clk); #1;
        tf_wdata = 64'd201; tf_rd = 1'b1;
        n_total++; if (tf_rdata !== 64'd200) $display("FAIL fifo_one_head: got %0d expected 200", tf_rdata); else n_pass++;
        @(posedge clk); #1;
        tf_wr = 1'b0; tf_rd = 1'b0;
        n_total++; if (tf_ne !== 1'b1 || tf_rdata !== 64'd201) $display("FAIL fifo_one_simul: got ne=%b data=%0d expected ne=1 data=201", tf_ne, tf_rdata); else n_pass++;
        tf_rd = 1'b1;
        @(posedge clk); #1;
        tf_rd = 1'b0;
    endtask

    task automatic test_reset_inflight;
        int nacc;
        int stale;
        in0_a = 64'h4012000000000000; in1_a = 64'hC00C000000000000;
        in0_stb = 1'b1; in1_stb = 1'b1; out0_ack = 1'b1; out1_ack = 1'b1;
        nacc = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (in0_ack || in1_ack) nacc++;
            @(posedge clk); #1;
        end
        n_total++; if (nacc != 2) $display("FAIL rif_accepts: got %0d expected 2", nacc); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (in0_ack !== 1'b0 || in1_ack !== 1'b0) $display("FAIL rif_ack_in_rst: got %b%b expected 00", in0_ack, in1_ack); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0; in0_stb = 1'b0; in1_stb = 1'b0;
        @(negedge clk);
        n_total++; if (floor_a !== 64'h0) $display("FAIL rif_floor_a: got %h expected 0", floor_a); else n_pass++;
        n_total++; if (out0_stb !== 1'b0 || out1_stb !== 1'b0) $display("FAIL rif_out_stb: got %b%b expected 00", out0_stb, out1_stb); else n_pass++;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out0_stb || out1_stb) stale++;
        end
        n_total++; if (stale != 0) $display("FAIL rif_stale: got %0d strobes expected 0", stale); else n_pass++;
        @(posedge clk); #1;
        in0_stb = 1'b1; in1_stb = 1'b1;
        @(negedge clk);
        n_total++; if (in0_ack !== 1'b1 || in1_ack !== 1'b0) $display("FAIL rif_first_tie: got %b%b expected 10", in0_ack, in1_ack); else n_pass++;
        @(posedge clk); #1;
        in0_stb = 1'b0; in1_stb = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_total++; if (q0.size() + q1.size() != 0) $display("FAIL rif_drain: got %0d pending expected 0", q0.size() + q1.size()); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; in0_stb = 1'b0; in1_stb = 1'b0; in0_a = '0; in1_a = '0;
        out0_ack = 1'b0; out1_ack = 1'b0;
        tf_wr = 1'b0; tf_rd = 1'b0; tf_wdata = '0;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_stream();
        test_fifo_full_simul();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
